// File: rtl/adc_snap_pkg.sv
// adc_snap_pkg
// Shared definitions for the ADC snapshot capture controller: FSM state
// encoding, control/status register bit positions and the negative-offset
// clamp helper.
// Ports: none (package).
package adc_snap_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_TRIG = 1;
  localparam int ST_DONE   = 31;
  localparam int ST_PRE    = 30;

  // Limit a negative offset to -(2**addr_w - 1) so the pre-window always
  // leaves room for at least the trigger sample itself.
  function automatic logic signed [31:0] clamp_offset(input logic signed [31:0] off,
                                                      input int addr_w);
    logic signed [31:0] lim;
    lim = 32'sd1 - (32'sd1 <<< addr_w);
    return (off < lim) ? lim : off;
  endfunction

endpackage

// File: rtl/adc_snap_capture_ctrl_if.sv
// adc_snap_capture_ctrl_if
// Sample stream in and BRAM write port out, bundled for the capture controller.
// Ports:
//   din_valid, din              - ADC sample strobe and data
//   bram_addr, bram_data,
//   bram_we                     - registered BRAM write port
// Modports: master = controller side, slave = source/BRAM side.
interface adc_snap_capture_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;

  modport master (input din_valid, din, output bram_addr, bram_data, bram_we);
  modport slave  (output din_valid, din, input bram_addr, bram_data, bram_we);
endinterface

// File: rtl/adc_snap_edge_det.sv
// adc_snap_edge_det
// Rising-edge detector with a registered history bit. The history resets to 0,
// so an input already high when reset releases reads as an edge.
// Ports:
//   clk, rst (async, active-high), d - sampled level
//   rise                             - d high now, low on the previous clock
module adc_snap_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/adc_snap_capture_ctrl.sv
// adc_snap_capture_ctrl
// Snapshot capture controller: arms from ctrl[0] rising, waits for a trigger
// (hardware trig or ctrl[1], qualified by din_valid), then fills a 2**ADDR_W
// word BRAM either after a post-trigger delay or around the trigger with a
// pre-trigger window (negative offset).
// Build option: define ADC_SNAP_PRETRIG_EN to enable the pre-trigger window;
// without it negative offsets behave as zero and status[30] reads 0.
// Ports:
//   user_clk, user_rst (async, active-high)
//   ctrl        - bit0 arm (edge), bit1 software trigger (level)
//   trig_offset - signed sample offset, latched on the arm edge
//   trig        - hardware trigger level
//   bus         - sample stream in / BRAM write port out (master modport)
//   status      - {done, pretrig_mode, 0..., words written[ADDR_W:0]}
//   trig_addr   - BRAM address of the trigger sample
//
//   state     | meaning
//   S_IDLE    | out of reset, nothing armed
//   S_PRE     | filling the circular pre-trigger window
//   S_WAIT    | armed, waiting for a trigger
//   S_DELAY   | counting post-trigger samples before writing
//   S_CAPTURE | writing the post-trigger part of the snapshot
//   S_DONE    | snapshot complete
module adc_snap_capture_ctrl
  import adc_snap_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [31:0]             ctrl,
  input  logic [31:0]             trig_offset,
  input  logic                    trig,
  adc_snap_capture_ctrl_if.master bus,
  output logic [31:0]             status,
  output logic [ADDR_W-1:0]       trig_addr
);
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic signed [31:0]  off_q;
  logic signed [31:0]  off_c;
  logic [31:0]         dly_cnt;
  logic [31:0]         dly_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   cap_left;
  logic [ADDR_W:0]     wcnt;
  logic                done_q;
  logic                pre_q;
  logic [ADDR_W-1:0]   p_len;
  logic                arm_edge;
  logic                trig_evt;
  logic                wr_en;
  logic                unused_ctrl;

  assign unused_ctrl = ^ctrl[31:2];

  adc_snap_edge_det u_arm_edge (
    .clk  (user_clk),
    .rst  (user_rst),
    .d    (ctrl[CTRL_ARM]),
    .rise (arm_edge)
  );

  assign trig_evt = (trig | ctrl[CTRL_TRIG]) & bus.din_valid;
  assign dly_nxt  = dly_cnt + 32'd1;

`ifdef ADC_SNAP_PRETRIG_EN
  logic [ADDR_W-1:0]  pre_cnt;
  logic signed [31:0] off_neg;

  always_comb begin
    off_c   = clamp_offset($signed(trig_offset), ADDR_W);
    off_neg = -off_c;
  end
`else
  assign off_c = trig_offset[31] ? 32'sd0 : $signed(trig_offset);
  assign p_len = '0;
  assign pre_q = 1'b0;
`endif

  // Write decode; an arm edge suppresses any write in its own cycle.
  // WAIT and DELAY only run with wr_ptr at 0, so wr_ptr is always the address.
  always_comb begin
    wr_en = 1'b0;
    if (!arm_edge && bus.din_valid) begin
      case (state)
        S_PRE, S_CAPTURE: wr_en = 1'b1;
        S_WAIT:           wr_en = trig_evt && (off_q == '0);
        S_DELAY:          wr_en = (dly_nxt == $unsigned(off_q));
        default:          wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state         <= S_IDLE;
      off_q         <= '0;
      dly_cnt       <= '0;
      wr_ptr        <= '0;
      cap_left      <= '0;
      wcnt          <= '0;
      done_q        <= 1'b0;
      trig_addr     <= '0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_data <= '0;
`ifdef ADC_SNAP_PRETRIG_EN
      pre_cnt       <= '0;
      p_len         <= '0;
      pre_q         <= 1'b0;
`endif
    end else begin
      bus.bram_we <= wr_en;
      if (wr_en) begin
        bus.bram_addr <= wr_ptr;
        bus.bram_data <= bus.din;
        wr_ptr        <= wr_ptr + 1'b1;
        if (wcnt != DEPTH_W) wcnt <= wcnt + 1'b1;
      end

      if (arm_edge) begin
        off_q     <= off_c;
        dly_cnt   <= '0;
        wr_ptr    <= '0;
        wcnt      <= '0;
        done_q    <= 1'b0;
        trig_addr <= '0;
`ifdef ADC_SNAP_PRETRIG_EN
        pre_cnt   <= '0;
        pre_q     <= off_c[31];
        p_len     <= off_c[31] ? off_neg[ADDR_W-1:0] : '0;
        state     <= off_c[31] ? S_PRE : S_WAIT;
`else
        state     <= S_WAIT;
`endif
      end else begin
        case (state)
`ifdef ADC_SNAP_PRETRIG_EN
          S_PRE: begin
            if (bus.din_valid) begin
              if (trig_evt && pre_cnt == p_len) begin
                trig_addr <= wr_ptr;
                // ~p_len = DEPTH-1-P post-trigger writes still to come
                cap_left  <= ~p_len;
                if (p_len == '1) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                end else begin
                  state  <= S_CAPTURE;
                end
              end else if (pre_cnt != p_len) begin
                pre_cnt <= pre_cnt + 1'b1;
              end
            end
          end
`endif
          S_WAIT: begin
            if (trig_evt) begin
              if (off_q == '0) begin
                cap_left <= '1;
                state    <= S_CAPTURE;
              end else begin
                dly_cnt  <= '0;
                state    <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            if (bus.din_valid) begin
              if (wr_en) begin
                cap_left <= '1;
                state    <= S_CAPTURE;
              end else begin
                dly_cnt  <= dly_nxt;
              end
            end
          end
          S_CAPTURE: begin
            if (bus.din_valid) begin
              if (cap_left == ADDR_W'(1)) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                cap_left <= cap_left - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status              = '0;
    status[ST_DONE]     = done_q;
    status[ST_PRE]      = pre_q;
    status[ADDR_W:0]    = wcnt;
  end

endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
module tb_adc_snap_capture_ctrl;
  import adc_snap_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
`ifdef ADC_SNAP_PRETRIG_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic          user_clk = 1'b0;
  logic          user_rst;
  logic [31:0]   ctrl;
  logic [31:0]   trig_offset;
  logic          trig;
  logic [31:0]   status;
  logic [AW-1:0] trig_addr;

  adc_snap_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  adc_snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .ctrl        (ctrl),
    .trig_offset (trig_offset),
    .trig        (trig),
    .bus         (bus),
    .status      (status),
    .trig_addr   (trig_addr)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  wr_t wq[$];
  bit  samp_ev[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // write monitor: one entry per BRAM write, with done as seen alongside it
  always @(negedge user_clk) begin
    if (!user_rst && bus.bram_we === 1'b1)
      wq.push_back('{addr: bus.bram_addr, data: bus.bram_data, done: status[31]});
  end

  task automatic drive_cycle(input bit v, input bit ev, input int k);
    int sel;
    bus.din_valid = v;
    bus.din       = v ? DW'(k) : ($urandom | 32'h8000_0000);
    if (v && ev) begin
      sel     = $urandom_range(0, 2);
      trig    = (sel != 1);
      ctrl[1] = (sel != 0);
    end else if (v) begin
      trig    = 1'b0;
      ctrl[1] = 1'b0;
    end else begin
      trig    = 1'($urandom_range(0, 1));
      ctrl[1] = 1'($urandom_range(0, 1));
    end
    ctrl[31:2]  = 30'($urandom);
    trig_offset = $urandom;
  endtask

  // Arms (unless already armed), streams samples numbered from 0 (first cycle
  // after the arm edge) with trigger events at sample indices t1/t2, then
  // compares the observed write stream with the expected snapshot.
  task automatic run_capture(input int off, input int t1, input int t2, input int vmode,
                             input int abort_at, input bit pre_armed, input string name);
    int k, post, p, t, n_exp, first, start, exp_addr, exp_data;
    bit v, ev, pre, done_seen, exp_done;
    logic [DW-1:0] mem [DEPTH];
    logic [31:0] exp_st;
    if (!pre_armed) begin
      @(posedge user_clk); #1;
      ctrl[0] = 1'b0; bus.din_valid = 1'b0; trig = 1'b0; ctrl[1] = 1'b0;
      @(posedge user_clk); #1;
      ctrl[0] = 1'b1; bus.din_valid = 1'b1; bus.din = 32'hDEAD_BEEF; trig = 1'b1;
      trig_offset = off;
    end
    wq.delete();
    samp_ev.delete();
    @(posedge user_clk); #1;
    n_checks++;
    if (status !== 32'h0 || bus.bram_we !== 1'b0 || trig_addr !== '0)
      $display("FAIL %s arm_clear: status=%h we=%b trig_addr=%0d, expected 0/0/0",
               name, status, bus.bram_we, trig_addr);
    else n_pass++;

    k = 0; post = 0; done_seen = 0;
    for (int cyc = 0; cyc < 800 && post < 4; cyc++) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      ev = v && (k == t1 || k == t2);
      drive_cycle(v, ev, k);
      if (v) begin
        samp_ev.push_back(ev);
        k++;
      end
      @(posedge user_clk); #1;
      if (abort_at > 0 && wq.size() >= abort_at) return;
      if (status[31]) done_seen = 1;
      if (done_seen) post++;
    end

    n_checks++;
    if (!done_seen) begin
      $display("FAIL %s done_timeout: done=%b after 800 cycles, expected 1", name, status[31]);
      return;
    end
    n_pass++;

    pre = PRE_EN && (off < 0);
    p   = pre ? ((-off > DEPTH - 1) ? DEPTH - 1 : -off) : 0;
    t   = -1;
    foreach (samp_ev[i]) if (t < 0 && samp_ev[i] && i >= p) t = i;
    n_checks++;
    if (t < 0) begin
      $display("FAIL %s trigger_seen: no qualifying trigger in %0d samples, expected one",
               name, samp_ev.size());
      return;
    end
    n_pass++;

    n_exp = pre ? t + DEPTH - p : DEPTH;
    first = pre ? 0 : t + ((off > 0) ? off : 0);
    n_checks++;
    if (wq.size() != n_exp)
      $display("FAIL %s write_count: got %0d writes, expected %0d", name, wq.size(), n_exp);
    else n_pass++;

    for (int i = 0; i < wq.size() && i < n_exp; i++) begin
      exp_addr = pre ? i % DEPTH : i;
      exp_data = pre ? i : first + i;
      exp_done = (i == n_exp - 1);
      n_checks++;
      if (wq[i].addr !== AW'(exp_addr) || wq[i].data !== DW'(exp_data) || wq[i].done !== exp_done)
        $display("FAIL %s write[%0d]: addr=%0d data=%0d done=%b, expected addr=%0d data=%0d done=%b",
                 name, i, wq[i].addr, wq[i].data, wq[i].done, exp_addr, exp_data, exp_done);
      else n_pass++;
    end

    exp_st = 32'h8000_0010 | (pre ? 32'h4000_0000 : 32'h0);
    n_checks++;
    if (status !== exp_st)
      $display("FAIL %s status: got %h, expected %h", name, status, exp_st);
    else n_pass++;

    n_checks++;
    if (trig_addr !== AW'(pre ? t % DEPTH : 0))
      $display("FAIL %s trig_addr: got %0d, expected %0d", name, trig_addr, pre ? t % DEPTH : 0);
    else n_pass++;

    foreach (mem[i]) mem[i] = 'x;
    foreach (wq[i]) mem[wq[i].addr] = wq[i].data;
    start = pre ? (t - p) % DEPTH : 0;
    n_checks++;
    if (mem[start] !== DW'(pre ? t - p : first))
      $display("FAIL %s readout_start: mem[%0d]=%0d, expected %0d",
               name, start, mem[start], pre ? t - p : first);
    else n_pass++;
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    ctrl = 32'h1; trig_offset = 32'h0; trig = 1'b1;
    bus.din_valid = 1'b1; bus.din = 32'hDEAD_BEEF;
    #22;
    n_checks++;
    if (bus.bram_we !== 1'b0 || bus.bram_addr !== '0 || bus.bram_data !== '0 ||
        status !== 32'h0 || trig_addr !== '0)
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h status=%h trig_addr=%0d, expected all 0",
               bus.bram_we, bus.bram_addr, bus.bram_data, status, trig_addr);
    else n_pass++;
    @(posedge user_clk); #1;
    user_rst = 1'b0;
    // arm held high through reset must count as an edge
    run_capture(0, 5, -1, 0, 0, 1'b1, "held_arm");
  endtask

  task automatic test_offsets();
    run_capture(0, 5, -1, 0, 0, 1'b0, "off_zero");
    run_capture(3, 5, -1, 0, 0, 1'b0, "off_pos3");
    run_capture(-4, 2, 10, 0, 0, 1'b0, "off_neg4");
    run_capture(-100, 3, 20, 2, 0, 1'b0, "off_clamp");
  endtask

  task automatic test_abort();
    run_capture(0, 1, -1, 0, 8, 1'b0, "abort_first");
    run_capture(0, 4, -1, 0, 0, 1'b0, "abort_rearm");
  endtask

  task automatic test_valid_toggle();
    run_capture(0, 3, -1, 1, 0, 1'b0, "toggle_off0");
    run_capture(5, 2, -1, 1, 0, 1'b0, "toggle_off5");
    run_capture(-6, 1, 9, 1, 0, 1'b0, "toggle_neg6");
  endtask

  task automatic test_random();
    int off, t1;
    for (int n = 0; n < 6; n++) begin
      off = int'($urandom_range(0, 40)) - 20;
      t1  = int'($urandom_range(0, 25));
      run_capture(off, t1, t1 + 16, 2, 0, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    run_capture(0, 1, -1, 0, 5, 1'b0, "rst_mid");
    n_checks++;
    if (bus.bram_we !== 1'b1)
      $display("FAIL rst_mid we_before: got %b, expected 1", bus.bram_we);
    else n_pass++;
    #2;
    user_rst = 1'b1;
    #1;
    n_checks++;
    if (bus.bram_we !== 1'b0 || status !== 32'h0 || bus.bram_addr !== '0)
      $display("FAIL rst_mid outputs: we=%b status=%h addr=%0d, expected 0/0/0",
               bus.bram_we, status, bus.bram_addr);
    else n_pass++;
    ctrl = 32'h0;
    bus.din_valid = 1'b0;
    @(posedge user_clk); #1;
    user_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_offsets();
    test_abort();
    test_valid_toggle();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
